// File: rtl/pool_writeback_if.sv
// Pooled-element input stream and packed-word output stream of the pool writeback block.
// The slave modport is the writeback engine; the master modport is whoever feeds and drains it.
interface pool_writeback_if #(
    parameter int BITS = 8
);
    logic            inValid;
    logic            inReady;
    logic [BITS-1:0] inData;
    logic            outValid;
    logic            outReady;
    logic [31:0]     outData;
    logic [31:0]     outAddr;

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outData, outAddr
    );

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outData, outAddr
    );
endinterface

// File: rtl/pool_writeback.sv
// Packs a row-major stream of pooled elements four-per-word (lane 0 in the top byte)
// and writes the words to consecutive addresses starting at a latched base address.
module pool_writeback #(
    parameter int BITS = 8,
    parameter int DIM  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] m,
    input  logic [31:0] p,
    input  logic [31:0] baseAddr,
    pool_writeback_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, PACK, HOLD, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] n_reg, n_next;        // element count of the pooled matrix
    logic [31:0] elem_reg, elem_next;  // elements transferred so far
    logic [31:0] word_reg, word_next;  // index of the word being built
    logic [31:0] base_reg, base_next;
    logic [31:0] data_reg, data_next;
    logic [1:0]  lane_reg, lane_next;
    logic        err_reg, err_next;

    logic            dims_ok;
    logic            xfer;
    logic            last_elem;
    logic [BITS-1:0] in_elem;
    logic [7:0]      elem_byte;
    logic [31:0]     lane_word;

    assign in_elem   = bus.inData;
    assign elem_byte = 8'(in_elem);

    // Current element positioned in the lane selected by lane_reg, other lanes zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_word[31-8*gi -: 8] = (lane_reg == 2'(gi)) ? elem_byte : 8'h00;
        end
    endgenerate

    assign dims_ok = (m[0] == 1'b0) && (p[0] == 1'b0) && (m != 32'd0) && (p != 32'd0)
                     && (m <= 32'(DIM)) && (p <= 32'(DIM));
    assign xfer      = bus.inValid && (state_reg == PACK);
    assign last_elem = (elem_reg == n_reg - 32'd1);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        elem_next  = elem_reg;
        word_next  = word_reg;
        base_next  = base_reg;
        data_next  = data_reg;
        lane_next  = lane_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        n_next     = (m >> 1) * (p >> 1);
                        elem_next  = 32'd0;
                        word_next  = 32'd0;
                        lane_next  = 2'd0;
                        data_next  = 32'd0;
                        base_next  = baseAddr;
                        err_next   = 1'b0;
                        state_next = PACK;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            PACK: begin
                if (xfer) begin
                    data_next = data_reg | lane_word;
                    elem_next = elem_reg + 32'd1;
                    lane_next = lane_reg + 2'd1;
                    if (lane_reg == 2'd3 || last_elem) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.outReady) begin
                    word_next  = word_reg + 32'd1;
                    data_next  = 32'd0;
                    lane_next  = 2'd0;
                    state_next = (elem_reg == n_reg) ? DONE : PACK;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= 32'd0;
            elem_reg  <= 32'd0;
            word_reg  <= 32'd0;
            base_reg  <= 32'd0;
            data_reg  <= 32'd0;
            lane_reg  <= 2'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            elem_reg  <= elem_next;
            word_reg  <= word_next;
            base_reg  <= base_next;
            data_reg  <= data_next;
            lane_reg  <= lane_next;
            err_reg   <= err_next;
        end
    end

    // Word outputs read zero outside HOLD so an idle or reset block presents nothing.
    assign bus.inReady  = (state_reg == PACK);
    assign bus.outValid = (state_reg == HOLD);
    assign bus.outData  = (state_reg == HOLD) ? data_reg : 32'd0;
    assign bus.outAddr  = (state_reg == HOLD) ? (base_reg + (word_reg << 2)) : 32'd0;
    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign err          = err_reg;
endmodule

// File: tb/tb_pool_writeback.sv
// Randomized scoreboard bench for pool_writeback: jobs push expected words into queues,
// a negedge monitor pops and compares every accepted word.
module tb_pool_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] m = 32'd0;
    logic [31:0] p = 32'd0;
    logic [31:0] base_addr = 32'd0;
    logic        busy, done, err;

    pool_writeback_if #(.BITS(8)) bus();

    pool_writeback #(.BITS(8), .DIM(32)) dut (
        .clk(clk), .rst(rst), .start(start), .m(m), .p(p), .baseAddr(base_addr),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0]  feed_q[$];
    logic [7:0]  job_bytes[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];
    bit          xfer_flag = 1'b0;
    int          xfer_count = 0;
    int          done_count = 0;
    int          stall = 0;
    bit          hold_valid = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] held_data, held_addr;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Element source: random gaps on inValid, pops after each accepted element.
    initial begin
        bus.inValid = 1'b0;
        bus.inData  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_flag && feed_q.size() > 0) void'(feed_q.pop_front());
            if (feed_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                bus.inValid = 1'b1;
                bus.inData  = feed_q[0];
            end else begin
                bus.inValid = 1'b0;
                bus.inData  = 8'($urandom);
            end
        end
    end

    // Word sink: holds outReady low for 'stall' cycles of each presented word.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.outReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.outValid) begin
                bus.outReady = (wait_cnt >= stall);
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                bus.outReady = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares accepted words against the scoreboard and watches done.
    initial begin
        forever begin
            @(negedge clk);
            xfer_flag = bus.inValid && bus.inReady && !rst;
            if (xfer_flag) xfer_count++;
            if (!rst) begin
                if (bus.outValid) begin
                    if (hold_valid) begin
                        check32("stable_data", bus.outData, held_data);
                        check32("stable_addr", bus.outAddr, held_addr);
                    end
                    if (bus.outReady) begin
                        if (exp_data_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word: got data 0x%08h addr 0x%08h, required none",
                                     bus.outData, bus.outAddr);
                        end else begin
                            check32("word_data", bus.outData, exp_data_q.pop_front());
                            check32("word_addr", bus.outAddr, exp_addr_q.pop_front());
                        end
                    end
                end
                hold_valid = bus.outValid && !bus.outReady;
                held_data  = bus.outData;
                held_addr  = bus.outAddr;
                if (done) begin
                    check32("done_single_cycle", {31'd0, prev_done}, 32'd0);
                    check32("words_left_at_done", exp_data_q.size(), 32'd0);
                    done_count++;
                end
                prev_done = done;
            end else begin
                hold_valid = 1'b0;
                prev_done  = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check32({tag, "_inReady"}, {31'd0, bus.inReady}, 32'd0);
        check32({tag, "_outValid"}, {31'd0, bus.outValid}, 32'd0);
        check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check32({tag, "_done"}, {31'd0, done}, 32'd0);
        check32({tag, "_err"}, {31'd0, err}, 32'd0);
        check32({tag, "_outData"}, bus.outData, 32'd0);
        check32({tag, "_outAddr"}, bus.outAddr, 32'd0);
    endtask

    // Reference: element k sits in word k/4, byte lane k%4 counted from the top byte.
    task automatic model_words(input logic [7:0] b[$], input logic [31:0] base);
        int n, nw;
        logic [31:0] word;
        n  = b.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            word = 32'd0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < n) word = word | (32'(b[4*w+l]) << (24 - 8 * l));
            end
            exp_data_q.push_back(word);
            exp_addr_q.push_back(base + 32'(4 * w));
        end
    endtask

    task automatic pulse_start(input int mm, input int pp, input logic [31:0] base);
        @(posedge clk);
        #1;
        start = 1'b1;
        m = 32'(mm);
        p = 32'(pp);
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t, d0;
        t  = 0;
        d0 = done_count;
        while (done_count == d0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (done_count == d0) begin
            errors++;
            $display("FAIL %s_timeout: got no done, required done within 20000 cycles", name);
        end
    endtask

    task automatic run_job(input int mm, input int pp, input logic [31:0] base, input bit inject);
        logic [7:0] b[$];
        int n;
        n = (mm / 2) * (pp / 2);
        if (job_bytes.size() == n) b = job_bytes;
        else for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        job_bytes.delete();
        $display("job m=%0d p=%0d base=0x%08h n=%0d stall=%0d", mm, pp, base, n, stall);
        model_words(b, base);
        feed_q = b;
        pulse_start(mm, pp, base);
        check32("start_busy", {31'd0, busy}, 32'd1);
        check32("start_inReady", {31'd0, bus.inReady}, 32'd1);
        check32("start_err", {31'd0, err}, 32'd0);
        if (inject) pulse_start(2, 2, 32'h0000_9990);
        wait_done("job");
        #1;
        check32("after_done_busy", {31'd0, busy}, 32'd0);
        check32("after_done_done", {31'd0, done}, 32'd0);
        check32("bytes_consumed", feed_q.size(), 32'd0);
    endtask

    task automatic bad_start(input int mm, input int pp);
        $display("bad start m=%0d p=%0d", mm, pp);
        pulse_start(mm, pp, 32'h0000_0100);
        check32("bad_err", {31'd0, err}, 32'd1);
        check32("bad_busy", {31'd0, busy}, 32'd0);
        check32("bad_inReady", {31'd0, bus.inReady}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check32("bad_err_held", {31'd0, err}, 32'd1);
    endtask

    initial begin
        int x0, t;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        job_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_job(4, 4, 32'h0000_1000, 1'b0);
        job_bytes = '{8'hAA, 8'hBB, 8'hCC};
        run_job(6, 2, 32'h0000_2000, 1'b0);

        bad_start(5, 4);
        bad_start(4, 0);
        bad_start(34, 4);
        run_job(2, 2, 32'h0000_0040, 1'b0);

        stall = 1;
        run_job(8, 8, 32'hFFFF_FFF8, 1'b0);
        for (int j = 0; j < 6; j++) begin
            stall = $urandom_range(0, 3);
            run_job(2 * $urandom_range(1, 16), 2 * $urandom_range(1, 16), $urandom, 1'b0);
        end

        stall = 10;
        run_job(32, 32, 32'h4000_0000, 1'b0);
        stall = 0;
        run_job(8, 8, 32'h0000_3000, 1'b1);

        // Reset after two elements of a 4-element job: nothing may be written.
        $display("reset mid-job");
        feed_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        x0 = xfer_count;
        pulse_start(4, 4, 32'h0000_5000);
        t = 0;
        while (xfer_count < x0 + 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (xfer_count < x0 + 2) begin
            errors++;
            $display("FAIL reset_job_xfer: got %0d elements, required 2", xfer_count - x0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        feed_q.delete();
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check32("post_reset_outValid", {31'd0, bus.outValid}, 32'd0);
        end
        job_bytes = '{8'h55, 8'h66, 8'h77, 8'h88};
        run_job(4, 4, 32'h0000_6000, 1'b0);

        repeat (5) @(posedge clk);
        check32("leftover_words", exp_data_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool_writeback.md
POOL_WRITEBACK -- requirements
Module: pool_writeback

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning pooled element width in bits.
REQ-002 SHALL have parameter DIM, default 32, meaning maximum pre-pool matrix dimension.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches m, p, baseAddr.
REQ-006 SHALL have ports m, p  input  32 each  pre-pool matrix dimensions; the pooled output is (m/2) x (p/2).
REQ-007 SHALL have port baseAddr  input  32  byte address of the first output word.
REQ-008 SHALL have ports inValid (input, 1), inReady (output, 1), inData (input, BITS)  pooled-element stream, row-major.
REQ-009 SHALL have ports outValid (output, 1), outReady (input, 1), outData (output, 32), outAddr (output, 32)  packed-word write stream.
REQ-010 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-011 SHALL implement states IDLE, PACK, HOLD, DONE.
REQ-012 SHALL, in IDLE on start, validate m and p: both even, nonzero and <= DIM; if valid, latch N = (m/2)*(p/2), clear the byte and word counters, clear err and go to PACK; if invalid, set err and stay in IDLE.
REQ-013 SHALL compute N from the latched values with at least 11-bit precision, without truncation for DIM=32.
REQ-014 SHALL drive inReady=1 only in PACK; an element transfers when inValid & inReady.
REQ-015 SHALL place transferred element k (k = 0..N-1) in lane k mod 4: lane 0 = outData[31:24], lane 1 = [23:16], lane 2 = [15:8], lane 3 = [7:0]; for BITS<8 the element is zero-extended into its lane.
REQ-016 SHALL move from PACK to HOLD in the cycle after the transfer of lane 3 or of element N-1, whichever comes first.
REQ-017 SHALL fill unused lanes of a partial final word with zero.
REQ-018 SHALL drive outValid=1 only in HOLD, with outData and outAddr stable until outReady=1.
REQ-019 SHALL set outAddr = baseAddr + 4*w, where w is the word index from 0; arithmetic is modulo 2^32.
REQ-020 SHALL, on HOLD with outReady=1, increment w, clear the lane buffer, and go to DONE if element N-1 has been packed, otherwise to PACK.
REQ-021 SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL drive busy=1 in PACK, HOLD and DONE.
REQ-023 SHALL ignore start outside IDLE; the latched values are unchanged.
REQ-024 SHALL accept no element in HOLD; there is no skid buffer, and the minimum period is one word per 5 cycles.
REQ-025 SHALL hold err until the next start in IDLE.

Reset
REQ-026 SHALL, while rst=1, force IDLE and set inReady, outValid, busy, done, err = 0 and outData, outAddr = 0 and all counters = 0; rst overrides start and in-flight handshakes.
REQ-027 SHALL discard a partially packed word on reset mid-operation; no outValid is asserted after reset until a new start.

Verification
REQ-028 SHALL pass: m=4, p=4, baseAddr=0x1000, bytes 0x11,0x22,0x33,0x44 -> one word 0x11223344 at 0x1000, then done pulse, 1 cycle.
REQ-029 SHALL pass: m=6, p=2, bytes 0xAA,0xBB,0xCC -> word 0xAABBCC00 at baseAddr, done.
REQ-030 SHALL pass: m=p=32, outReady low 10 cycles per word -> 64 words at base+0..base+252, stable while stalled, no lost bytes.
REQ-031 SHALL pass: start with m=5 or p=0 or m=34 -> err=1, busy=0, inReady=0; a later valid start clears err.
REQ-032 SHALL pass: rst pulse after 2 bytes of an m=p=4 job -> IDLE, all outputs 0, no word emitted; a new job packs from lane 0.
REQ-033 SHALL pass: start pulsed during PACK with different m -> ignored, original N completes.
